// File: rtl/hp_pkg.sv
// Shared constants for the hoggephase alarm monitor and the sensor-side modules:
// 3-bit FSM encoding, the glitch pulse width and a counter-width helper.
package hp_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_MON  = 3'd2;
    localparam logic [2:0] S_TRIP = 3'd3;
    localparam logic [2:0] S_TEST = 3'd4;

    // One CK2 data phase of the sensor equals two CK cycles.
    localparam int GLITCH_CYCLES = 2;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hp_alarm_filter.sv
// Per-sensor alarm filter: counts consecutive high samples, pulses qual_o on the
// edge the count reaches FILTER_LEN, and keeps the sticky ALARM_SRC bit.
module hp_alarm_filter
    import hp_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic CK,
    input  logic RSTN,
    input  logic en_i,
    input  logic cnt_clr_i,
    input  logic sticky_clr_i,
    input  logic alarm_i,
    output logic qual_o,
    output logic src_o
);

    localparam int CW = width_for(FILTER_LEN);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          src_q, src_d;

    // Count saturates at FILTER_LEN, so a held alarm qualifies only once.
    assign qual_o = en_i && alarm_i && (cnt_q == CW'(FILTER_LEN - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (!en_i || cnt_clr_i || !alarm_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(FILTER_LEN)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A clear on the same edge as a qualification keeps only the new bit.
    assign src_d = sticky_clr_i ? qual_o : (src_q | qual_o);

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            cnt_q <= '0;
            src_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            src_q <= src_d;
        end
    end

    assign src_o = src_q;

endmodule

// File: rtl/hp_alarm_monitor.sv
// Consumer side of the hoggephase sensor interface: powers, blanks and filters
// N sensors into sticky alarm flags and a saturating event count.
// Optional self-test sequencer is built when HP_SELFTEST_EN is defined.
module hp_alarm_monitor
    import hp_pkg::*;
#(
    parameter int N_SENSORS  = 4,
    parameter int FILTER_LEN = 3,
    parameter int ARM_CYCLES = 8,
    parameter int CNT_W      = 8,
    parameter int TEST_WIN   = 8
) (
    input  logic                 CK,
    input  logic                 RSTN,
    input  logic                 EN,
    input  logic [N_SENSORS-1:0] ALARM_IN,
    input  logic                 CLEAR,
    output logic                 VCC_OUT,
    output logic                 ALARM_OUT,
    output logic [N_SENSORS-1:0] ALARM_SRC,
    output logic [CNT_W-1:0]     ALARM_CNT,
    input  logic                 ST_START,
    output logic [N_SENSORS-1:0] GLITCH,
    output logic                 ST_DONE,
    output logic [N_SENSORS-1:0] ST_PASS
);

    localparam int BLANK_W = width_for(ARM_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [BLANK_W-1:0]   blank_q, blank_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_SENSORS-1:0] qual, src;
    logic                 filt_en, trip_clear, sticky_clr, any_qual;

    assign filt_en    = EN && ((state_q == S_MON) || (state_q == S_TRIP));
    assign any_qual   = |qual;
    assign trip_clear = EN && (state_q == S_TRIP) && CLEAR && !any_qual;
    assign sticky_clr = CLEAR && (state_q != S_TEST);

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_filt
        hp_alarm_filter #(
            .FILTER_LEN(FILTER_LEN)
        ) u_filt (
            .CK          (CK),
            .RSTN        (RSTN),
            .en_i        (filt_en),
            .cnt_clr_i   (trip_clear),
            .sticky_clr_i(sticky_clr),
            .alarm_i     (ALARM_IN[i]),
            .qual_o      (qual[i]),
            .src_o       (src[i])
        );
    end

`ifdef HP_SELFTEST_EN
    localparam logic [1:0] PH_GLITCH  = 2'd0;
    localparam logic [1:0] PH_OBSERVE = 2'd1;
    localparam logic [1:0] PH_RECOVER = 2'd2;
    localparam logic [1:0] PH_DONE    = 2'd3;
    localparam int TW_W  = width_for(TEST_WIN - 1);
    localparam int IDX_W = width_for(N_SENSORS - 1);

    logic [1:0]           ph_q, ph_d;
    logic [TW_W-1:0]      tcnt_q, tcnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_SENSORS-1:0] pass_q, pass_d;
    logic                 st_enter, st_finish;

    assign st_enter  = EN && (state_q == S_MON) && ST_START && !any_qual;
    assign st_finish = (ph_q == PH_DONE);

    // Per sensor: glitch pulse, observe window, recovery gap; then one DONE cycle.
    always_comb begin
        ph_d   = ph_q;
        tcnt_d = tcnt_q;
        idx_d  = idx_q;
        pass_d = pass_q;
        if ((state_q == S_TEST) && !EN) begin
            pass_d = '0;
        end else if (st_enter) begin
            pass_d = '0;
            idx_d  = '0;
            ph_d   = PH_GLITCH;
            tcnt_d = TW_W'(GLITCH_CYCLES - 1);
        end else if (state_q == S_TEST) begin
            case (ph_q)
                PH_GLITCH: begin
                    if (tcnt_q == '0) begin
                        ph_d   = PH_OBSERVE;
                        tcnt_d = TW_W'(TEST_WIN - 1);
                    end else begin
                        tcnt_d = tcnt_q - TW_W'(1);
                    end
                end
                PH_OBSERVE: begin
                    if (ALARM_IN[idx_q]) pass_d[idx_q] = 1'b1;
                    if (tcnt_q == '0) begin
                        ph_d   = PH_RECOVER;
                        tcnt_d = TW_W'(TEST_WIN - 1);
                    end else begin
                        tcnt_d = tcnt_q - TW_W'(1);
                    end
                end
                PH_RECOVER: begin
                    if (tcnt_q != '0) begin
                        tcnt_d = tcnt_q - TW_W'(1);
                    end else if (idx_q == IDX_W'(N_SENSORS - 1)) begin
                        ph_d = PH_DONE;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        ph_d   = PH_GLITCH;
                        tcnt_d = TW_W'(GLITCH_CYCLES - 1);
                    end
                end
                default: ph_d = PH_DONE;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            ph_q   <= PH_GLITCH;
            tcnt_q <= '0;
            idx_q  <= '0;
            pass_q <= '0;
        end else begin
            ph_q   <= ph_d;
            tcnt_q <= tcnt_d;
            idx_q  <= idx_d;
            pass_q <= pass_d;
        end
    end

    assign GLITCH  = ((state_q == S_TEST) && (ph_q == PH_GLITCH)) ?
                     (N_SENSORS'(1) << idx_q) : '0;
    assign ST_DONE = (state_q == S_TEST) && (ph_q == PH_DONE);
    assign ST_PASS = pass_q;
`else
    logic unused_st;
    assign unused_st = ST_START & (TEST_WIN >= 4);
    assign GLITCH    = '0;
    assign ST_DONE   = 1'b0;
    assign ST_PASS   = '0;
`endif

    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        if (!EN) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                    blank_d = BLANK_W'(ARM_CYCLES - 1);
                end
                // Sensors report Alarm=1 while powering up; ALARM_IN is ignored here.
                S_ARM: begin
                    if (blank_q == '0) state_d = S_MON;
                    else               blank_d = blank_q - BLANK_W'(1);
                end
                S_MON: begin
                    if (any_qual) state_d = S_TRIP;
`ifdef HP_SELFTEST_EN
                    else if (st_enter) state_d = S_TEST;
`endif
                end
                S_TRIP: begin
                    if (trip_clear) begin
                        state_d = S_ARM;
                        blank_d = BLANK_W'(ARM_CYCLES - 1);
                    end
                end
`ifdef HP_SELFTEST_EN
                S_TEST: begin
                    if (st_finish) begin
                        state_d = S_ARM;
                        blank_d = BLANK_W'(ARM_CYCLES - 1);
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Simultaneous qualifications count as one event.
    assign cnt_d = (any_qual && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge CK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!RSTN) begin
            state_q <= S_IDLE;
            blank_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            cnt_q   <= cnt_d;
        end
    end

    assign VCC_OUT   = (state_q != S_IDLE);
    assign ALARM_SRC = src;
    assign ALARM_OUT = |src;
    assign ALARM_CNT = cnt_q;

endmodule

// File: tb/tb_hp_alarm_monitor.sv
// Directed bench for hp_alarm_monitor: power-up blanking, qualification, clear
// priority, counter saturation (CNT_W=2 copy), reset/EN, and self-test if built.
module tb_hp_alarm_monitor;
    import hp_pkg::*;

    logic       CK = 1'b0;
    logic       RSTN = 1'b0;
    logic       EN = 1'b0;
    logic       CLEAR = 1'b0;
    logic       ST_START = 1'b0;
    logic [3:0] alarm_drv = 4'h0;
    logic [3:0] sensor_resp;
    logic [3:0] ALARM_IN;

    logic       VCC_OUT, ALARM_OUT, ST_DONE;
    logic [3:0] ALARM_SRC, GLITCH, ST_PASS;
    logic [7:0] ALARM_CNT;

    logic       s_vcc, s_out, s_done;
    logic [3:0] s_src, s_glitch, s_pass;
    logic [1:0] s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    // Sensor model: alive sensors answer a glitch with Alarm 3 cycles later.
    logic [3:0] g1 = '0, g2 = '0, g3 = '0;
    always @(posedge CK) begin
        g1 <= GLITCH;
        g2 <= g1;
        g3 <= g2;
    end
    assign sensor_resp = g3 & 4'b1011;
    assign ALARM_IN    = alarm_drv | sensor_resp;

    hp_alarm_monitor dut (
        .CK(CK), .RSTN(RSTN), .EN(EN), .ALARM_IN(ALARM_IN), .CLEAR(CLEAR),
        .VCC_OUT(VCC_OUT), .ALARM_OUT(ALARM_OUT), .ALARM_SRC(ALARM_SRC),
        .ALARM_CNT(ALARM_CNT), .ST_START(ST_START), .GLITCH(GLITCH),
        .ST_DONE(ST_DONE), .ST_PASS(ST_PASS)
    );

    hp_alarm_monitor #(.CNT_W(2)) dut_s (
        .CK(CK), .RSTN(RSTN), .EN(EN), .ALARM_IN(ALARM_IN), .CLEAR(CLEAR),
        .VCC_OUT(s_vcc), .ALARM_OUT(s_out), .ALARM_SRC(s_src),
        .ALARM_CNT(s_cnt), .ST_START(ST_START), .GLITCH(s_glitch),
        .ST_DONE(s_done), .ST_PASS(s_pass)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge CK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        check("rst_vcc", VCC_OUT, 0);
        check("rst_out", ALARM_OUT, 0);
        check("rst_src", ALARM_SRC, 0);
        check("rst_cnt", ALARM_CNT, 0);
        check("rst_state", dut.state_q, S_IDLE);
        RSTN = 1'b1;

        // Power-up: start-up alarms on all sensors are blanked.
        EN = 1'b1; alarm_drv = 4'hF;
        step();
        check("pu_vcc", VCC_OUT, 1);
        check("pu_state_arm", dut.state_q, S_ARM);
        step(7);
        check("pu_still_arm", dut.state_q, S_ARM);
        check("pu_blanked", ALARM_OUT, 0);
        alarm_drv = 4'h0;
        step();
        check("pu_mon", dut.state_q, S_MON);
        check("pu_src", ALARM_SRC, 0);

        // Qualification after 3 consecutive samples.
        alarm_drv = 4'b0100;
        step(2);
        check("q_early", ALARM_OUT, 0);
        step();
        check("q_src", ALARM_SRC, 4'b0100);
        check("q_out", ALARM_OUT, 1);
        check("q_cnt", ALARM_CNT, 1);
        check("q_trip", dut.state_q, S_TRIP);
        step();
        check("q_held_once", ALARM_CNT, 1);
        alarm_drv = 4'b0010;
        step(2);
        alarm_drv = 4'b0000;
        step();
        check("short_src", ALARM_SRC, 4'b0100);
        check("short_cnt", ALARM_CNT, 1);

        // CLEAR in TRIP re-arms; then simultaneous qualification.
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        check("clr_arm", dut.state_q, S_ARM);
        check("clr_src", ALARM_SRC, 0);
        check("clr_out", ALARM_OUT, 0);
        check("clr_cnt_kept", ALARM_CNT, 1);
        step(8);
        check("clr_mon", dut.state_q, S_MON);
        alarm_drv = 4'b1001;
        step(3);
        check("sim_src", ALARM_SRC, 4'b1001);
        check("sim_cnt", ALARM_CNT, 2);
        check("sim_cnt_s", s_cnt, 2);
        alarm_drv = 4'b0000;
        step();

        // CLEAR and a new qualification on the same edge: qualification wins.
        alarm_drv = 4'b0010;
        step(2);
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0; alarm_drv = 4'b0000;
        check("cq_src", ALARM_SRC, 4'b0010);
        check("cq_out", ALARM_OUT, 1);
        check("cq_trip", dut.state_q, S_TRIP);
        check("cq_cnt", ALARM_CNT, 3);
        check("cq_cnt_s", s_cnt, 3);

        // Two more events: 8-bit count reaches 5, 2-bit count saturates at 3.
        for (int k = 0; k < 2; k++) begin
            CLEAR = 1'b1;
            step();
            CLEAR = 1'b0;
            step(8);
            check("sat_mon", dut.state_q, S_MON);
            alarm_drv = 4'b0001;
            step(3);
            alarm_drv = 4'b0000;
            step();
        end
        check("sat_cnt", ALARM_CNT, 5);
        check("sat_cnt_s", s_cnt, 3);

        // Reset in TRIP.
        RSTN = 1'b0;
        step();
        check("mrst_out", ALARM_OUT, 0);
        check("mrst_src", ALARM_SRC, 0);
        check("mrst_cnt", ALARM_CNT, 0);
        check("mrst_vcc", VCC_OUT, 0);
        check("mrst_state", dut.state_q, S_IDLE);
        RSTN = 1'b1;
        step(9);
        check("re_mon", dut.state_q, S_MON);
        alarm_drv = 4'b1000;
        step(3);
        alarm_drv = 4'b0000;
        check("re_trip", dut.state_q, S_TRIP);

        // EN drop keeps flags; CLEAR in IDLE zeroes them.
        EN = 1'b0;
        step();
        check("en_vcc", VCC_OUT, 0);
        check("en_idle", dut.state_q, S_IDLE);
        check("en_src_kept", ALARM_SRC, 4'b1000);
        check("en_cnt_kept", ALARM_CNT, 1);
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        check("en_clr_src", ALARM_SRC, 0);
        check("en_clr_out", ALARM_OUT, 0);

        EN = 1'b1;
        step(9);
        check("st_mon", dut.state_q, S_MON);
`ifdef HP_SELFTEST_EN
        begin
            int done_cnt = 0;
            int glitch_bits = 0;
            bit reached = 1'b0;
            ST_START = 1'b1;
            step();
            ST_START = 1'b0;
            check("st_test", dut.state_q, S_TEST);
            check("st_pass_clr", ST_PASS, 0);
            for (int k = 0; k < 200 && !reached; k++) begin
                glitch_bits += $countones(GLITCH);
                if (ST_DONE) done_cnt++;
                step();
                if (dut.state_q == S_ARM) reached = 1'b1;
            end
            check("st_reached_arm", reached, 1);
            check("st_done_once", done_cnt, 1);
            check("st_glitch_cycles", glitch_bits, 8);
            check("st_pass", ST_PASS, 4'b1011);
            check("st_cnt", ALARM_CNT, 1);
            check("st_src", ALARM_SRC, 0);
            step();
            check("st_pass_held", ST_PASS, 4'b1011);
            check("st_done_low", ST_DONE, 0);
        end
`else
        ST_START = 1'b1;
        step();
        ST_START = 1'b0;
        check("nost_mon", dut.state_q, S_MON);
        check("nost_glitch", GLITCH, 0);
        check("nost_done", ST_DONE, 0);
        check("nost_pass", ST_PASS, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
